// File: rtl/multi_dma_controller_if.sv
// Bus-side signal bundle of the multi-channel DMA controller.
// The DMA engine takes the master view; the CPU/RAM environment takes the slave view.
interface multi_dma_controller_if #(
  parameter int NUM_BLK = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
);
  logic                      ce;
  logic                      odd_cycle;
  logic                      cpu_read;
  logic [NUM_BLK-1:0]        blk_trigger;
  logic [7:0]                data_from_cpu;
  logic [NUM_BLK*ADDR_W-1:0] blk_dest;
  logic                      fetch_req;
  logic [ADDR_W-1:0]         fetch_addr;
  logic [DATA_W-1:0]         data_from_ram;
  logic [ADDR_W-1:0]         aout;
  logic                      aout_enable;
  logic                      read;
  logic [DATA_W-1:0]         data_to_ram;
  logic                      fetch_ack;
  logic [NUM_BLK-1:0]        blk_busy;
  logic [NUM_BLK-1:0]        blk_done;
  logic                      pause_cpu;

  modport master (
    input  ce, odd_cycle, cpu_read, blk_trigger, data_from_cpu, blk_dest,
           fetch_req, fetch_addr, data_from_ram,
    output aout, aout_enable, read, data_to_ram, fetch_ack, blk_busy, blk_done, pause_cpu
  );

  modport slave (
    output ce, odd_cycle, cpu_read, blk_trigger, data_from_cpu, blk_dest,
           fetch_req, fetch_addr, data_from_ram,
    input  aout, aout_enable, read, data_to_ram, fetch_ack, blk_busy, blk_done, pause_cpu
  );
endinterface

// File: rtl/multi_dma_controller.sv
// Multi-channel DMA: index-prioritised block-copy channels (read on even, write on odd cycles)
// plus a single-byte fetch channel that steals an even slot from an active copy.
module multi_dma_controller #(
  parameter int NUM_BLK = 2,
  parameter int BLK_LEN = 256,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
) (
  input logic                    clk,
  input logic                    reset_n,
  multi_dma_controller_if.master bus
);
  localparam int CW = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
  localparam int IW = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;

  typedef enum logic [1:0] {BLK_IDLE, BLK_PEND, BLK_ACTIVE} blk_state_t;
  typedef enum logic {FETCH_IDLE, FETCH_WAIT} fetch_state_t;

  blk_state_t [NUM_BLK-1:0]        blk_state, blk_state_next;
  logic [NUM_BLK-1:0][ADDR_W-1:0]  src, src_next;
  logic [NUM_BLK-1:0][CW-1:0]      count, count_next;
  logic [NUM_BLK-1:0]              done, done_next;
  fetch_state_t                    fetch_state, fetch_state_next;
  logic [DATA_W-1:0]               latch, latch_next;

  logic               any_active;
  logic [IW-1:0]      act_idx;
  logic [NUM_BLK-1:0] grant;
  logic               blocked;
  logic               start_ok, fetch_wait, act_even, act_odd;
  logic [ADDR_W-1:0]  page_base, act_src, act_dest;
  logic [CW-1:0]      act_count;

  assign page_base  = ADDR_W'({{ADDR_W{1'b0}}, bus.data_from_cpu} << CW);
  assign fetch_wait = (fetch_state == FETCH_WAIT);
  assign start_ok   = bus.cpu_read && bus.odd_cycle && !fetch_wait;

  // Only one channel may own the copy engine; a pending lower index blocks all higher ones.
  always_comb begin
    any_active = 1'b0;
    act_idx    = '0;
    grant      = '0;
    for (int i = 0; i < NUM_BLK; i++) begin
      if (blk_state[i] == BLK_ACTIVE) begin
        any_active = 1'b1;
        act_idx    = IW'(i);
      end
    end
    blocked = any_active;
    for (int i = 0; i < NUM_BLK; i++) begin
      if (blk_state[i] == BLK_PEND && !blocked) grant[i] = 1'b1;
      if (blk_state[i] != BLK_IDLE) blocked = 1'b1;
    end
  end

  assign act_src   = src[act_idx];
  assign act_count = count[act_idx];
  assign act_dest  = bus.blk_dest[act_idx*ADDR_W +: ADDR_W];

  always_comb begin
    blk_state_next   = blk_state;
    src_next         = src;
    count_next       = count;
    done_next        = '0;
    latch_next       = latch;
    fetch_state_next = fetch_state;
    for (int i = 0; i < NUM_BLK; i++) begin
      if (bus.blk_trigger[i]) begin
        src_next[i]       = page_base;
        count_next[i]     = '0;
        blk_state_next[i] = BLK_PEND;
      end else begin
        case (blk_state[i])
          BLK_PEND:
            if (grant[i] && start_ok) blk_state_next[i] = BLK_ACTIVE;
          BLK_ACTIVE:
            if (!bus.odd_cycle) begin
              // A fetch owning this even slot pushes the copy back to PEND with count kept.
              if (fetch_wait) blk_state_next[i] = BLK_PEND;
            end else begin
              count_next[i] = count[i] + 1'b1;
              if (&count[i]) begin
                blk_state_next[i] = BLK_IDLE;
                done_next[i]      = 1'b1;
              end
            end
          default: ;
        endcase
      end
    end
    if (any_active && !bus.odd_cycle && !fetch_wait) latch_next = bus.data_from_ram;
    case (fetch_state)
      FETCH_IDLE: if (bus.fetch_req && bus.cpu_read && !bus.odd_cycle) fetch_state_next = FETCH_WAIT;
      FETCH_WAIT: if (!bus.odd_cycle) fetch_state_next = FETCH_IDLE;
      default:    fetch_state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BLK; i++) blk_state[i] <= BLK_IDLE;
      src         <= '0;
      count       <= '0;
      done        <= '0;
      fetch_state <= FETCH_IDLE;
      latch       <= '0;
    end else if (bus.ce) begin
      blk_state   <= blk_state_next;
      src         <= src_next;
      count       <= count_next;
      done        <= done_next;
      fetch_state <= fetch_state_next;
      latch       <= latch_next;
    end
  end

  assign bus.fetch_ack   = bus.ce && fetch_wait && !bus.odd_cycle;
  assign act_even        = bus.ce && any_active && !bus.odd_cycle && !fetch_wait;
  assign act_odd         = bus.ce && any_active && bus.odd_cycle;
  assign bus.aout_enable = bus.fetch_ack || act_even || act_odd;
  assign bus.read        = !act_odd;
  assign bus.data_to_ram = latch;
  assign bus.blk_done    = done;

  always_comb begin
    bus.aout = '0;
    if (bus.fetch_ack)  bus.aout = bus.fetch_addr;
    else if (act_even)  bus.aout = act_src | ADDR_W'(act_count);
    else if (act_odd)   bus.aout = act_dest;
  end

  always_comb begin
    bus.blk_busy = '0;
    for (int i = 0; i < NUM_BLK; i++) bus.blk_busy[i] = (blk_state[i] != BLK_IDLE);
  end

  assign bus.pause_cpu = ((|bus.blk_busy) || bus.fetch_req || fetch_wait) && bus.cpu_read;
endmodule
